// File: rtl/cl_pkg.sv
// Shared types for the bit-serial logic-cell sequencer: opcodes, FSM states, widths.
package cl_pkg;

    localparam int unsigned CL_OP_W = 3;

    typedef enum logic [CL_OP_W-1:0] {
        CL_AND     = 3'd0,
        CL_NAND    = 3'd1,
        CL_OR      = 3'd2,
        CL_NOR     = 3'd3,
        CL_XOR     = 3'd4,
        CL_XNOR    = 3'd5,
        CL_NOT     = 3'd6,
        CL_ILLEGAL = 3'd7
    } cl_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } cl_state_e;

endpackage

// File: rtl/cl_bit_alu.sv
// Combinational 1-bit logic cell: evaluates every gate function and selects one by opcode.
module cl_bit_alu
    import cl_pkg::*;
(
    input  logic   a,
    input  logic   b,
    input  cl_op_e op,
    output logic   y
);

    logic g_and, g_or, g_xor;

    assign g_and = a & b;
    assign g_or  = a | b;
    assign g_xor = a ^ b;

    always_comb begin
        y = 1'b0;
        case (op)
            CL_AND:  y = g_and;
            CL_NAND: y = ~g_and;
            CL_OR:   y = g_or;
            CL_NOR:  y = ~g_or;
            CL_XOR:  y = g_xor;
            CL_XNOR: y = ~g_xor;
            CL_NOT:  y = ~a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/cl_serial_seq.sv
// Bit-serial sequencer: steps one shared logic cell over WIDTH bit positions, LSB first,
// between a command handshake and a result handshake.
module cl_serial_seq
    import cl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [CL_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_err,
    output logic               o_busy
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    cl_state_e        state_q, state_d;
    cl_op_e           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             err_q, err_d;
    logic             cell_y;

    cl_bit_alu u_cell (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .op (op_q),
        .y  (cell_y)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    op_d     = cl_op_e'(i_op);
                    a_d      = i_a;
                    b_d      = i_b;
                    result_d = '0;
                    idx_d    = '0;
                    if (cl_op_e'(i_op) == CL_ILLEGAL) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                result_d[idx_q] = cell_y;
                // Terminal compare on WIDTH-1 so non-power-of-2 widths never wrap.
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            op_q     <= CL_AND;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_valid  = (state_q == StDone);
    assign o_busy   = (state_q != StIdle);
    assign o_result = result_q;
    assign o_err    = err_q;

endmodule

// File: doc/cl_serial_seq.md
# cl_serial_seq

Bit-serial sequencer for the 1-bit logic cell. It accepts a WIDTH-bit operand pair and an opcode over a valid/ready handshake. It then steps a single shared 1-bit logic cell across all bit positions, LSB first, one bit per cycle, and returns the assembled WIDTH-bit result over a second valid/ready handshake. It sits between a command source (CPU-side register block or test driver) and the result consumer. Its purpose is to trade latency for area: one logic cell serves any operand width.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..64.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  command valid.
- o_ready  output  1  command ready; high only in IDLE.
- i_op  input  3  opcode: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT (of i_a; i_b ignored), 7 illegal.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- o_valid  output  1  result valid; high only in DONE.
- i_ready  input  1  result consumer ready.
- o_result  output  WIDTH  result; stable while o_valid=1.
- o_err  output  1  set with o_valid when the opcode was illegal.
- o_busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&o_ready, capture i_a, i_b and i_op; clear the result register and o_err; set bit index idx=0.
  - If op is 0..6, go to RUN. If op is 7, go to DONE with result 0 and o_err=1.
- RUN:
  - Each cycle, drive cell inputs with a[idx] and b[idx]. Write the selected cell output into result[idx].
  - Increment idx. When idx==WIDTH-1 is written, go to DONE.
- DONE:
  - o_valid=1. Hold o_result and o_err until i_valid... no: until i_ready=1, then go to IDLE.
  - o_err stays 0 for legal ops.
- idx is a $clog2(WIDTH)-bit counter with no wrap. Its terminal compare is on WIDTH-1, so non-power-of-2 WIDTH is legal.
- Captured operands are not re-sampled. Changes on i_a, i_b or i_op after acceptance have no effect.
- i_valid is ignored outside IDLE, with no queueing. The source holds the command until o_ready.
- Reset in any state:
  - Next state is IDLE; any partial result is discarded.
  - o_valid=0, o_err=0, o_busy=0, o_result=0, o_ready=1.
  - No handshake is accepted in a cycle where i_rst=1.

## Timing
- Accept at cycle T → RUN during T+1..T+WIDTH → o_valid=1 from cycle T+WIDTH+1.
- Illegal op: accept at T → o_valid=1 at T+1.
- With i_ready held high, the result handshake completes at T+WIDTH+1 and IDLE is reached at T+WIDTH+2. Minimum command spacing is WIDTH+2 cycles.
- o_ready, o_valid and o_busy decode registered state only; there is no combinational path from inputs.
- The cell is purely combinational: the cell output is registered into result the same cycle idx is presented.

## Structure
- Shared package cl_pkg holds:
  - the opcode enum (CL_AND..CL_NOT, CL_ILLEGAL=7);
  - the FSM state enum;
  - the opcode width constant CL_OP_W=3.
- One sub-module, cl_bit_alu:
  - combinational 1-bit cell with inputs a, b and op;
  - computes all seven gate functions and muxes one out by op.
- Top module contains the FSM, idx counter, operand registers and result register.

## Test plan
- Reset: assert i_rst 2 cycles mid-idle → o_ready=1, o_valid=0, o_busy=0, o_err=0, o_result=0.
- WIDTH=8, AND, a=0xF0, b=0xCC, accepted at cycle T → o_valid rises exactly at T+9, o_result=0xC0, o_err=0.
- XNOR a=0xA5 b=0x0F → 0x55. NOT a=0xA5 b=0xFF → 0x5A. NOR a=0x00 b=0x01 → 0xFE. Run back-to-back, each accepted at the earliest o_ready.
- Backpressure: i_ready=0 for 5 cycles in DONE, with i_valid=1 and new operands driven → o_result unchanged, o_ready=0, no second accept. The result handshake completes on the first i_ready=1 cycle.
- Illegal op 7, a=0xFF, b=0xFF → o_valid at T+1, o_result=0x00, o_err=1. The next legal command clears o_err.
- Reset mid-RUN after idx=3 is written → IDLE the next cycle, and o_valid never asserts for that command. A following OR a=0x0F b=0xF0 returns 0xFF.
